iddr_word_aligner: RTL and testbench

// - Training/bitslip controller behind one iddr lane. Gears the q1/q2 bit pair into WORD_W-bit words.
// - On request, slips the word boundary one bit at a time until TRAIN_PATTERN is seen LOCK_COUNT times in a row.
// - Lets downstream logic receive word-aligned source-synchronous data. Single clock domain: same clk as the iddr.

---
 rtl/iddr_word_aligner.sv | 164 ++++++++++++++++
 tb/tb_iddr_word_aligner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iddr_word_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iddr_word_aligner                                            |
// | Description : Gears an iddr q1/q2 bit pair into WORD_W-bit words and runs  |
// |               a training-pattern bitslip search until the boundary locks.  |
// |               Optional: define IDDR_WORD_ALIGNER_STATS_EN for err_cnt.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module iddr_word_aligner #(
    parameter int                 WORD_W        = 8,
    parameter logic [WORD_W-1:0]  TRAIN_PATTERN = 8'hA5,
    parameter int                 LOCK_COUNT    = 4,
    parameter int                 MAX_SLIPS     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       q1,
    input  logic                       q2,
    input  logic                       align_start,
    output logic [WORD_W-1:0]          word_o,
    output logic                       word_valid,
    output logic                       locked,
    output logic                       align_busy,
    output logic                       align_fail,
    output logic [$clog2(WORD_W)-1:0]  slip_offset,
    output logic [7:0]                 slip_count
`ifdef IDDR_WORD_ALIGNER_STATS_EN
    ,
    output logic [15:0]                err_cnt
`endif
);

    localparam int                 c_OFF_W    = $clog2(WORD_W);
    localparam int                 c_PH_W     = $clog2(WORD_W / 2);
    localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(WORD_W / 2 - 1);
    localparam logic [c_OFF_W-1:0] c_OFF_LAST = c_OFF_W'(WORD_W - 1);
    localparam logic [3:0]         c_LOCK     = 4'(LOCK_COUNT);
    localparam logic [7:0]         c_MAX      = 8'(MAX_SLIPS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_SLIP   = 3'd2,
        S_LOCKED = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    logic [2*WORD_W-1:0] r_win;
    logic [2*WORD_W-1:0] w_win_next;
    logic [c_PH_W-1:0]   r_phase;
    logic [WORD_W-1:0]   r_word;
    logic                r_word_valid;

    state_t              r_state, w_state_nxt;
    logic [c_OFF_W-1:0]  r_off, w_off_nxt;
    logic [3:0]          r_match, w_match_nxt, w_match_inc;
    logic [7:0]          r_slip, w_slip_nxt, w_slip_inc;
    logic                w_unused;

    // Newest pair enters at the bottom; q1 is the earlier bit so it sits above q2.
    assign w_win_next = {r_win[2*WORD_W-3:0], q1, q2};
    assign w_unused   = &{1'b0, r_win[2*WORD_W-1:2*WORD_W-2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win        <= '0;
            r_phase      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_win        <= w_win_next;
            r_phase      <= (r_phase == c_PH_LAST) ? '0 : r_phase + 1'b1;
            r_word_valid <= (r_phase == c_PH_LAST);
            if (r_phase == c_PH_LAST)
                r_word <= w_win_next[r_off +: WORD_W];
        end
    end

    assign w_match_inc = r_match + 4'd1;
    assign w_slip_inc  = (r_slip == 8'hFF) ? r_slip : r_slip + 8'd1;

`ifdef IDDR_WORD_ALIGNER_STATS_EN
    logic [15:0] r_err, w_err_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_off_nxt   = r_off;
        w_match_nxt = r_match;
        w_slip_nxt  = r_slip;
`ifdef IDDR_WORD_ALIGNER_STATS_EN
        w_err_nxt   = r_err;
`endif
        // A restart pre-empts any compare scheduled for the same cycle.
        if (align_start) begin
            w_state_nxt = S_SEARCH;
            w_off_nxt   = '0;
            w_match_nxt = '0;
            w_slip_nxt  = '0;
`ifdef IDDR_WORD_ALIGNER_STATS_EN
            w_err_nxt   = '0;
`endif
        end else begin
            case (r_state)
                S_SEARCH: begin
                    if (r_word_valid) begin
                        if (r_word == TRAIN_PATTERN) begin
                            w_match_nxt = w_match_inc;
                            if (w_match_inc == c_LOCK)
                                w_state_nxt = S_LOCKED;
                        end else begin
                            w_match_nxt = '0;
                            w_off_nxt   = (r_off == c_OFF_LAST) ? '0 : r_off + 1'b1;
                            w_slip_nxt  = w_slip_inc;
                            w_state_nxt = (w_slip_inc == c_MAX) ? S_FAIL : S_SLIP;
`ifdef IDDR_WORD_ALIGNER_STATS_EN
                            w_err_nxt   = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
`endif
                        end
                    end
                end
                // The first strobe after a slip may straddle the old and new boundary.
                S_SLIP: begin
                    if (r_word_valid)
                        w_state_nxt = S_SEARCH;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_off   <= '0;
            r_match <= '0;
            r_slip  <= '0;
`ifdef IDDR_WORD_ALIGNER_STATS_EN
            r_err   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_off   <= w_off_nxt;
            r_match <= w_match_nxt;
            r_slip  <= w_slip_nxt;
`ifdef IDDR_WORD_ALIGNER_STATS_EN
            r_err   <= w_err_nxt;
`endif
        end
    end

    assign word_o      = r_word;
    assign word_valid  = r_word_valid;
    assign locked      = (r_state == S_LOCKED);
    assign align_busy  = (r_state == S_SEARCH) || (r_state == S_SLIP);
    assign align_fail  = (r_state == S_FAIL);
    assign slip_offset = r_off;
    assign slip_count  = r_slip;
`ifdef IDDR_WORD_ALIGNER_STATS_EN
    assign err_cnt     = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iddr_word_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_iddr_word_aligner                                         |
// | Description : Directed bench for iddr_word_aligner (W=8, A5, lock 4, 16).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_iddr_word_aligner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       q1 = 1'b0;
    logic       q2 = 1'b0;
    logic       align_start = 1'b0;
    logic [7:0] word_o;
    logic       word_valid;
    logic       locked;
    logic       align_busy;
    logic       align_fail;
    logic [2:0] slip_offset;
    logic [7:0] slip_count;
`ifdef IDDR_WORD_ALIGNER_STATS_EN
    logic [15:0] err_cnt;
`endif

    always #5 clk = ~clk;

    iddr_word_aligner #(
        .WORD_W        (8),
        .TRAIN_PATTERN (8'hA5),
        .LOCK_COUNT    (4),
        .MAX_SLIPS     (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .q1          (q1),
        .q2          (q2),
        .align_start (align_start),
        .word_o      (word_o),
        .word_valid  (word_valid),
        .locked      (locked),
        .align_busy  (align_busy),
        .align_fail  (align_fail),
        .slip_offset (slip_offset),
        .slip_count  (slip_count)
`ifdef IDDR_WORD_ALIGNER_STATS_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         nb    = 0;   // index of the next stream bit to drive
    int         dly   = 0;   // pattern phase: bit b carries pat[7-((b+dly)%8)]
    int         zu    = 0;   // bits below this index are forced to 0
    logic [7:0] pat   = 8'hA5;

    function automatic logic sbit(input int b);
        if (b < zu)
            return 1'b0;
        return pat[7 - ((b + dly) % 8)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_pair();
        q1 = sbit(nb);
        q2 = sbit(nb + 1);
        nb += 2;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive_pair();
    endtask

    // what: 0 locked, 1 align_fail, 2 word_valid, 3 slip_count>=2; n=limit+1 on timeout
    task automatic wait_for(input int what, input int limit, output int n);
        logic hit;
        n   = limit + 1;
        hit = 1'b0;
        for (int i = 1; i <= limit && !hit; i++) begin
            cyc();
            case (what)
                0:       hit = locked;
                1:       hit = align_fail;
                2:       hit = word_valid;
                default: hit = (slip_count >= 8'd2);
            endcase
            if (hit)
                n = i;
        end
    endtask

    task automatic start_align();
        align_start = 1'b1;
        cyc();
        align_start = 1'b0;
    endtask

    task automatic sync_strobe();
        int n;
        wait_for(2, 20, n);
        chk("sync_strobe", 32'(n <= 4), 32'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_word",   32'(word_o), 32'h0);
        chk("rst_valid",  32'(word_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_busy",   32'(align_busy), 32'd0);
        chk("rst_fail",   32'(align_fail), 32'd0);
        chk("rst_off",    32'(slip_offset), 32'd0);
        chk("rst_cnt",    32'(slip_count), 32'd0);
        rst = 1'b0;
        nb  = 0;
        drive_pair();

        // Aligned A5 stream: lock with no slips
        sync_strobe();
        start_align();
        chk("t1_busy", 32'(align_busy), 32'd1);
        wait_for(0, 100, n);
        chk("t1_lock_lat", n, 32'd16);
        chk("t1_off",  32'(slip_offset), 32'd0);
        chk("t1_cnt",  32'(slip_count), 32'd0);
        chk("t1_busy_done", 32'(align_busy), 32'd0);
        chk("t1_word", 32'(word_o), 32'hA5);

        // Pattern 3 bits early: three slips then lock
        dly = 3;
        sync_strobe();
        start_align();
        wait_for(0, 200, n);
        chk("t2_lock_lat", n, 32'd40);
        chk("t2_off", 32'(slip_offset), 32'd3);
        chk("t2_cnt", 32'(slip_count), 32'd3);

        // Constant zero: exhaust MAX_SLIPS
        zu = 32'h7fffffff;
        sync_strobe();
        start_align();
        wait_for(1, 300, n);
        chk("t3_fail_lat", n, 32'd124);
        chk("t3_fail",   32'(align_fail), 32'd1);
        chk("t3_locked", 32'(locked), 32'd0);
        chk("t3_busy",   32'(align_busy), 32'd0);
        chk("t3_cnt",    32'(slip_count), 32'd16);
        chk("t3_off",    32'(slip_offset), 32'd0);
`ifdef IDDR_WORD_ALIGNER_STATS_EN
        chk("t3_err", 32'(err_cnt), 32'd16);
`endif
        start_align();
        chk("t3_fail_clr", 32'(align_fail), 32'd0);
        chk("t3_busy_again", 32'(align_busy), 32'd1);
        chk("t3_cnt_clr", 32'(slip_count), 32'd0);

        // Lock at offset 0, then relock after a 1-bit delay
        zu  = 0;
        dly = 0;
        sync_strobe();
        start_align();
        wait_for(0, 100, n);
        chk("t4_lock0_lat", n, 32'd16);
        dly = 7;
        sync_strobe();
        start_align();
        chk("t4_unlock", 32'(locked), 32'd0);
        wait_for(0, 200, n);
        chk("t4_relock_lat", n, 32'd72);
        chk("t4_off", 32'(slip_offset), 32'd7);
        chk("t4_cnt", 32'(slip_count), 32'd7);

        // Asynchronous reset mid-search
        zu = 32'h7fffffff;
        sync_strobe();
        start_align();
        wait_for(3, 100, n);
        chk("t5_two_slips", 32'(slip_count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_word",   32'(word_o), 32'h0);
        chk("t5_valid",  32'(word_valid), 32'd0);
        chk("t5_busy",   32'(align_busy), 32'd0);
        chk("t5_off",    32'(slip_offset), 32'd0);
        chk("t5_cnt",    32'(slip_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nb  = 0;
        zu  = 0;
        dly = 0;
        drive_pair();
        wait_for(2, 10, n);
        chk("t5_valid_lat", n, 32'd4);
        repeat (20) cyc();
        chk("t5_idle_busy",   32'(align_busy), 32'd0);
        chk("t5_idle_locked", 32'(locked), 32'd0);
        chk("t5_idle_fail",   32'(align_fail), 32'd0);
        sync_strobe();
        start_align();
        wait_for(0, 100, n);
        chk("t5_lock_lat", n, 32'd16);

`ifdef IDDR_WORD_ALIGNER_STATS_EN
        // Two zero words then A5 at offset 2: err_cnt counts the two misses
        zu = 32'h7fffffff;
        sync_strobe();
        zu  = nb - 2 + 24;
        dly = 2;
        start_align();
        wait_for(0, 100, n);
        chk("t6_lock_lat", n, 32'd32);
        chk("t6_err", 32'(err_cnt), 32'd2);
        chk("t6_off", 32'(slip_offset), 32'd2);
        chk("t6_cnt", 32'(slip_count), 32'd2);
        start_align();
        chk("t6_err_clr", 32'(err_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
